// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - SPI NOR flash operation sequencer (READ_ID, READ, SECTOR_ERASE, PAGE_PROGRAM)
module spi_flash_seq #(
    parameter int          MAXCMD   = 256,
    parameter logic [15:0] POLL_MAX = 16'd65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [23:0]               req_addr,
    input  logic [8:0]                req_len,
    input  logic                      wdata_valid,
    input  logic [7:0]                wdata,
    output logic                      wdata_ready,
    output logic                      done,
    output logic                      error,
    output logic [63:0]               rdata,
    output logic                      trigger,
    input  logic                      busy,
    output logic [8:0]                data_in_count,
    output logic [7:0]                data_out_count,
    output logic [(4+MAXCMD)*8-1:0]   data_in,
    input  logic [63:0]               data_out,
    output logic                      quad
);
    localparam int         DW     = (4 + MAXCMD) * 8;
    localparam logic [9:0] MAXLEN = 10'(MAXCMD);

    localparam logic [1:0] OP_READ_ID = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;
    localparam logic [1:0] OP_PROGRAM = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_WREN, S_LOAD, S_CMD, S_POLL, S_DONE} state_t;
    typedef enum logic [1:0] {SUB_ISSUE, SUB_WAIT_HI, SUB_WAIT_LO} sub_t;

    state_t          state_q, state_d;
    sub_t            sub_q, sub_d;
    logic [1:0]      op_q, op_d;
    logic [23:0]     addr_q, addr_d;
    logic [8:0]      len_q, len_d;
    logic [DW-1:0]   data_in_q, data_in_d;
    logic [8:0]      din_cnt_q, din_cnt_d;
    logic [7:0]      dout_cnt_q, dout_cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [15:0]     poll_cnt_q, poll_cnt_d;

    logic spi_state;
    logic xfer_done;

    assign spi_state = (state_q == S_WREN) || (state_q == S_CMD) || (state_q == S_POLL);
    assign xfer_done = spi_state && (sub_q == SUB_WAIT_LO) && !busy;

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        data_in_d  = data_in_q;
        din_cnt_d  = din_cnt_q;
        dout_cnt_d = dout_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;

        if (spi_state) begin
            case (sub_q)
                SUB_ISSUE:   if (!busy) sub_d = SUB_WAIT_HI;
                SUB_WAIT_HI: if (busy)  sub_d = SUB_WAIT_LO;
                default:     if (!busy) sub_d = SUB_ISSUE;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !busy) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    len_d  = req_len;
                    err_d  = 1'b0;
                    sub_d  = SUB_ISSUE;
                    case (req_op)
                        OP_READ_ID: begin
                            data_in_d       = '0;
                            data_in_d[7:0]  = 8'h9F;
                            din_cnt_d       = 9'd1;
                            dout_cnt_d      = 8'd3;
                            state_d         = S_CMD;
                        end
                        OP_READ: begin
                            if (req_len >= 9'd1 && req_len <= 9'd8) begin
                                data_in_d       = '0;
                                data_in_d[31:0] = {8'h03, req_addr};
                                din_cnt_d       = 9'd4;
                                dout_cnt_d      = req_len[7:0];
                                state_d         = S_CMD;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            // Erase and program both open with a write-enable.
                            if (req_op == OP_PROGRAM &&
                                (req_len == 9'd0 || {1'b0, req_len} > MAXLEN)) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                data_in_d      = '0;
                                data_in_d[7:0] = 8'h06;
                                din_cnt_d      = 9'd1;
                                dout_cnt_d     = 8'd0;
                                state_d        = S_WREN;
                            end
                        end
                    endcase
                end
            end
            S_WREN: begin
                if (xfer_done) begin
                    data_in_d  = '0;
                    din_cnt_d  = 9'd4;
                    dout_cnt_d = 8'd0;
                    sub_d      = SUB_ISSUE;
                    if (op_q == OP_PROGRAM) begin
                        data_in_d[31:0] = {8'h02, addr_q};
                        state_d         = S_LOAD;
                    end else begin
                        data_in_d[31:0] = {8'hD8, addr_q};
                        state_d         = S_CMD;
                    end
                end
            end
            S_LOAD: begin
                // Header is already in place; payload bytes shift in behind it.
                if (wdata_valid) begin
                    data_in_d = {data_in_q[DW-9:0], wdata};
                    din_cnt_d = din_cnt_q + 9'd1;
                    if (din_cnt_q + 9'd1 == len_q + 9'd4) begin
                        state_d = S_CMD;
                        sub_d   = SUB_ISSUE;
                    end
                end
            end
            S_CMD: begin
                if (xfer_done) begin
                    case (op_q)
                        OP_READ_ID: begin
                            rdata_d = {40'b0, data_out[23:0]};
                            state_d = S_DONE;
                        end
                        OP_READ: begin
                            rdata_d = data_out;
                            state_d = S_DONE;
                        end
                        default: begin
                            data_in_d      = '0;
                            data_in_d[7:0] = 8'h05;
                            din_cnt_d      = 9'd1;
                            dout_cnt_d     = 8'd1;
                            poll_cnt_d     = 16'd0;
                            state_d        = S_POLL;
                        end
                    endcase
                end
            end
            S_POLL: begin
                if (xfer_done) begin
                    if (!data_out[0]) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if ({1'b0, poll_cnt_q} + 17'd1 >= {1'b0, POLL_MAX}) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sub_q      <= SUB_ISSUE;
            op_q       <= 2'd0;
            addr_q     <= 24'd0;
            len_q      <= 9'd0;
            data_in_q  <= '0;
            din_cnt_q  <= 9'd0;
            dout_cnt_q <= 8'd0;
            rdata_q    <= 64'd0;
            err_q      <= 1'b0;
            poll_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            data_in_q  <= data_in_d;
            din_cnt_q  <= din_cnt_d;
            dout_cnt_q <= dout_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign trigger        = spi_state && (sub_q == SUB_ISSUE) && !busy && !reset;
    assign req_ready      = (state_q == S_IDLE) && !busy;
    assign wdata_ready    = (state_q == S_LOAD);
    assign done           = (state_q == S_DONE);
    assign error          = done && err_q;
    assign rdata          = rdata_q;
    assign data_in        = data_in_q;
    assign data_in_count  = din_cnt_q;
    assign data_out_count = dout_cnt_q;
    assign quad           = 1'b0;
endmodule
